// File: rtl/burst_mem_requester.sv
// burst_mem_requester
// Initiator-side bridge: accepts a burst command, checks it against the
// protected address window, then issues one single-cycle chip-select beat per
// cycle on the memory port. Read data and write/error status come back on a
// registered valid/ready response channel.
module burst_mem_requester #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LEN_WIDTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] PRIV_BASE  = 8'hF0
) (
  input  logic                  clk,
  input  logic                  reset,
  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_priv,
  // write data stream
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  rsp_err,
  // memory port
  output logic                  mem_cs,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WRITE,
    READ,
    DRAIN,
    DONE,
    ERR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  wr_q;
  logic                  priv_q;
  logic [LEN_WIDTH-1:0]  beat_cnt_q;

  // One extra bit so a burst running past the top of the address space is
  // visible as a carry instead of silently wrapping.
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  fault;
  logic                  last_beat;
  logic                  rsp_free;
  logic                  beat_fire;

  assign end_addr  = {1'b0, addr_q} + (ADDR_WIDTH+1)'(len_q);
  // The all-ones address is a redirect location and is refused even to
  // privileged requesters.
  assign fault     = end_addr[ADDR_WIDTH]
                   | (end_addr == {1'b0, {ADDR_WIDTH{1'b1}}})
                   | (!priv_q && (end_addr >= {1'b0, PRIV_BASE}));
  assign last_beat = (beat_cnt_q == len_q);
  // A read beat may only be issued when its data has somewhere to land.
  assign rsp_free  = !rsp_valid || rsp_ready;

  // The window check guarantees base + beat_cnt never wraps.
  assign mem_addr  = reset ? '0 : addr_q + ADDR_WIDTH'(beat_cnt_q);
  assign busy      = !reset && (state_q != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and combinational handshake/memory-strobe decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    cmd_ready      = 1'b0;
    wr_ready       = 1'b0;
    mem_cs         = 1'b0;
    mem_wr         = 1'b0;
    mem_write_data = '0;
    beat_fire      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = CHECK;
      end
      CHECK: begin
        if (fault)     state_d = ERR;
        else if (wr_q) state_d = WRITE;
        else           state_d = READ;
      end
      WRITE: begin
        wr_ready       = 1'b1;
        mem_cs         = wr_valid;
        mem_wr         = wr_valid;
        mem_write_data = wr_data;
        beat_fire      = wr_valid;
        if (wr_valid && last_beat) state_d = DONE;
      end
      READ: begin
        mem_cs    = rsp_free;
        beat_fire = rsp_free;
        if (rsp_free && last_beat) state_d = DRAIN;
      end
      DRAIN, DONE, ERR: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset abandons any burst immediately: no beat may leak out during the
    // reset cycle itself.
    if (reset) begin
      cmd_ready      = 1'b0;
      wr_ready       = 1'b0;
      mem_cs         = 1'b0;
      mem_wr         = 1'b0;
      mem_write_data = '0;
      beat_fire      = 1'b0;
    end
  end

  // Command capture, beat counting and the registered response channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      len_q      <= '0;
      wr_q       <= 1'b0;
      priv_q     <= 1'b0;
      beat_cnt_q <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_last   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (beat_fire) beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q     <= cmd_addr;
            len_q      <= cmd_len;
            wr_q       <= cmd_wr;
            priv_q     <= cmd_priv;
            beat_cnt_q <= '0;
          end
        end
        CHECK: begin
          if (fault) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_last  <= 1'b1;
            rsp_data  <= '0;
          end
        end
        WRITE: begin
          if (wr_valid && last_beat) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_last  <= 1'b1;
            rsp_data  <= '0;
          end
        end
        READ: begin
          if (rsp_free) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_last  <= last_beat;
            rsp_data  <= mem_read_data;
          end
        end
        DRAIN, DONE, ERR: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_mem_requester.sv
// tb_burst_mem_requester
// Scoreboard bench: each command pushes its predicted memory beats and
// responses into queues; a negedge monitor pops and compares whatever the DUT
// presents. The reference model is a plain word array updated per command.
module tb_burst_mem_requester;

  localparam int PRIV_BASE = 'hF0;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wbeat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic        cmd_priv = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        mem_cs;
  logic        mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        busy;

  burst_mem_requester #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .LEN_WIDTH (4),
    .PRIV_BASE (8'hF0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_wr        (cmd_wr),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_priv      (cmd_priv),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_last      (rsp_last),
    .rsp_err       (rsp_err),
    .mem_cs        (mem_cs),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bookkeeping shared by stimulus and monitor.
  int          n_vec = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          acc_cyc = 0;
  bit          mon_en = 1'b0;
  int          rdy_mode = 0;
  bit          rdy_pat[$];
  rsp_t        exp_rsp[$];
  wbeat_t      exp_wr[$];
  logic [7:0]  exp_rd[$];
  int          wr_cyc_q[$];
  logic [31:0] ref_mem[256];
  logic [31:0] slave_mem[256];
  logic [31:0] cur_data[16];

  function automatic logic [31:0] init_word(input int i);
    return {16'hC0DE, 8'(i), 8'(~i)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory slave: combinational read, write on the clock edge.
  assign mem_read_data = slave_mem[mem_addr];
  initial begin
    for (int i = 0; i < 256; i++) slave_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_cs && mem_wr) slave_mem[mem_addr] <= mem_write_data;
    end
  end

  // Response back-pressure: always ready, random, or a scripted pattern that
  // advances only on cycles presenting a response.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (rdy_pat.size() > 0 && rsp_valid) rsp_ready = rdy_pat.pop_front();
          else                                 rsp_ready = 1'b1;
        end
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents a beat or response.
  bit          prev_hold = 1'b0;
  logic [33:0] held_rsp;
  always @(negedge clk) begin
    if (mon_en) begin
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        acc_cyc = cyc;
      end
      if (mem_cs) begin
        if (mem_wr) begin
          wr_cyc_q.push_back(cyc);
          check("wr_has_handshake", wr_valid && wr_ready, 1);
          if (exp_wr.size() == 0) check("wr_beat_expected", exp_wr.size() == 0, 0);
          else                    check("wr_beat", {mem_addr, mem_write_data}, exp_wr.pop_front());
        end else begin
          check("rd_reg_free", rsp_valid && !rsp_ready, 0);
          if (exp_rd.size() == 0) check("rd_beat_expected", exp_rd.size() == 0, 0);
          else                    check("rd_beat_addr", mem_addr, exp_rd.pop_front());
        end
      end
      if (prev_hold) check("rsp_hold", {rsp_valid, rsp_data, rsp_last, rsp_err}, {1'b1, held_rsp});
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) check("rsp_expected", exp_rsp.size() == 0, 0);
        else                     check("rsp", {rsp_data, rsp_last, rsp_err}, exp_rsp.pop_front());
      end
      prev_hold = rsp_valid && !rsp_ready && !reset;
      held_rsp  = {rsp_data, rsp_last, rsp_err};
    end
  end

  // Reference model: decide the window check and queue the expected traffic.
  task automatic predict(input bit wr, input logic [7:0] addr, input logic [3:0] len,
                         input bit priv, input logic [31:0] dbase, output bit fault);
    int e;
    e = int'(addr) + int'(len);
    fault = (e > 255) || (e == 255) || (!priv && e >= PRIV_BASE);
    for (int k = 0; k <= int'(len); k++)
      cur_data[k] = (dbase != 0) ? dbase + 32'(k) : $urandom;
    if (fault) begin
      exp_rsp.push_back('{data: 32'h0, last: 1'b1, err: 1'b1});
    end else if (wr) begin
      for (int k = 0; k <= int'(len); k++) begin
        exp_wr.push_back('{addr: 8'(int'(addr) + k), data: cur_data[k]});
        ref_mem[8'(int'(addr) + k)] = cur_data[k];
      end
      exp_rsp.push_back('{data: 32'h0, last: 1'b1, err: 1'b0});
    end else begin
      for (int k = 0; k <= int'(len); k++)
        exp_rsp.push_back('{data: ref_mem[8'(int'(addr) + k)], last: (k == int'(len)), err: 1'b0});
      for (int k = 0; k <= int'(len); k++) exp_rd.push_back(8'(int'(addr) + k));
    end
  endtask

  // Present a command and return in the cycle after it is accepted.
  task automatic issue_cmd(input bit wr, input logic [7:0] addr, input logic [3:0] len, input bit priv);
    int t;
    cmd_wr = wr; cmd_addr = addr; cmd_len = len; cmd_priv = priv;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 100) begin step(); t++; end
    check("cmd_accept_timeout", t >= 100, 0);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input bit watch_wr_ready);
    int t;
    bit seen;
    t = 0;
    seen = 1'b0;
    while (exp_rsp.size() > 0 && t < 300) begin
      seen |= wr_ready;
      step();
      t++;
    end
    wr_valid = 1'b0;
    check("rsp_drain", exp_rsp.size(), 0);
    step();
    check("beats_done", exp_wr.size() + exp_rd.size(), 0);
    if (watch_wr_ready) check("err_no_wr_ready", seen, 0);
    exp_rsp.delete(); exp_wr.delete(); exp_rd.delete();
  endtask

  task automatic run_cmd(input bit wr, input logic [7:0] addr, input logic [3:0] len,
                         input bit priv, input bit gaps, input logic [31:0] dbase);
    bit fault;
    int i, t;
    predict(wr, addr, len, priv, dbase, fault);
    issue_cmd(wr, addr, len, priv);
    if (fault) begin
      wr_valid = wr;
      wr_data  = cur_data[0];
      check("err_not_early", rsp_valid, 0);
      step();
      check("err_at_t2", {rsp_valid, rsp_err, rsp_last}, 3'b111);
      wait_done(wr);
    end else if (wr) begin
      i = 0;
      t = 0;
      while (i <= int'(len) && t < 200) begin
        wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        wr_data  = cur_data[i];
        if (wr_valid && wr_ready) i++;
        step();
        t++;
      end
      wr_valid = 1'b0;
      check("wr_beats_timeout", t >= 200, 0);
      check("done_next_cycle", {rsp_valid, rsp_last, rsp_err}, 3'b110);
      wait_done(1'b0);
    end else begin
      wait_done(1'b0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          f;
    int          i, t, n0;
    logic [7:0]  a;
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);

    // Reset values, then ready in the first idle cycle.
    step();
    step();
    check("reset_outs", {cmd_ready, wr_ready, rsp_valid, rsp_last, rsp_err, mem_cs, mem_wr,
                         busy, mem_addr, rsp_data, mem_write_data}, 0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", {cmd_ready, busy}, 2'b10);
    mon_en = 1'b1;

    // Back-to-back 4-beat write, then read it back under back-pressure.
    wr_cyc_q.delete();
    run_cmd(1'b1, 8'h10, 4'd3, 1'b0, 1'b0, 32'hA0);
    check("wr_beat_count", wr_cyc_q.size(), 4);
    if (wr_cyc_q.size() == 4) begin
      check("wr_first_at_t2", wr_cyc_q[0] - acc_cyc, 2);
      check("wr_consecutive", wr_cyc_q[3] - wr_cyc_q[0], 3);
    end
    rdy_mode = 2;
    rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_cmd(1'b0, 8'h10, 4'd3, 1'b0, 1'b0, 32'h0);
    rdy_pat.delete();
    rdy_mode = 0;

    // Window protection.
    run_cmd(1'b1, 8'hEE, 4'd2, 1'b0, 1'b0, 32'h0);
    run_cmd(1'b1, 8'hEE, 4'd2, 1'b1, 1'b0, 32'h0);
    run_cmd(1'b0, 8'hFC, 4'd3, 1'b1, 1'b0, 32'h0);
    run_cmd(1'b0, 8'hFE, 4'd4, 1'b1, 1'b0, 32'h0);
    run_cmd(1'b0, 8'hEE, 4'd2, 1'b1, 1'b0, 32'h0);

    // Reset after the second beat of a 4-beat write.
    for (int k = 0; k < 4; k++) cur_data[k] = 32'hB0 + 32'(k);
    for (int k = 0; k < 2; k++) begin
      exp_wr.push_back('{addr: 8'(8'h20 + k), data: cur_data[k]});
      ref_mem[8'h20 + k] = cur_data[k];
    end
    issue_cmd(1'b1, 8'h20, 4'd3, 1'b0);
    i = 0;
    t = 0;
    while (i < 2 && t < 50) begin
      wr_valid = 1'b1;
      wr_data  = cur_data[i];
      if (wr_ready) i++;
      step();
      t++;
    end
    reset    = 1'b1;
    wr_data  = cur_data[2];
    step();
    reset    = 1'b0;
    wr_valid = 1'b0;
    #1;
    check("rst_mid_idle", {busy, cmd_ready}, 2'b01);
    step();
    step();
    check("rst_mid_beats", exp_wr.size(), 0);
    exp_wr.delete();
    run_cmd(1'b0, 8'h20, 4'd3, 1'b0, 1'b0, 32'h0);

    // cmd_valid held through a busy read: second command taken exactly once.
    rdy_mode = 1;
    n0 = n_acc;
    predict(1'b0, 8'h10, 4'd3, 1'b0, 32'h0, f);
    predict(1'b0, 8'h40, 4'd1, 1'b0, 32'h0, f);
    issue_cmd(1'b0, 8'h10, 4'd3, 1'b0);
    cmd_addr = 8'h40; cmd_len = 4'd1; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 200) begin step(); t++; end
    check("hold_second_pending", exp_rsp.size(), 2);
    step();
    cmd_valid = 1'b0;
    wait_done(1'b0);
    check("hold_accept_once", n_acc - n0, 2);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      rdy_mode = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       a = 8'($urandom_range(0, 255));
        1:       a = 8'($urandom_range(8'hE0, 8'hFF));
        default: a = 8'($urandom_range(0, 8'h7F));
      endcase
      run_cmd(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
